mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for the shared single-ported 16-bit memory (fetch vs. load/store).
// Define ARB_ROUND_ROBIN_EN to alternate grants on conflicts; default is fixed dm-over-fetch priority.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_err,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] LP_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_owner_dm;
  logic        r_wr;
  logic        r_err;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_if_rdata;
  logic [15:0] r_dm_rdata;
  logic        w_any;
  logic        w_pick_dm;
  logic        w_grant;
  logic [15:0] w_req_addr;

  assign w_any      = if_req | dm_req;
  assign w_grant    = (r_state == S_IDLE) && w_any;
  assign w_req_addr = w_pick_dm ? dm_addr : if_addr;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who won last; starts as fetch so the first conflict goes to dm.
  logic r_last_dm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_dm <= 1'b0;
    end else if (w_grant) begin
      r_last_dm <= w_pick_dm;
    end
  end

  assign w_pick_dm = dm_req & (~if_req | ~r_last_dm);
`else
  assign w_pick_dm = dm_req;
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          if (w_req_addr[0]) begin
            w_state_next = S_RESP;
          end else if (WAIT_CYCLES > 0) begin
            w_state_next = S_WAIT;
            w_cnt_next   = LP_WAIT_LOAD;
          end else begin
            w_state_next = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_ACCESS;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_ACCESS: w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_owner_dm <= 1'b0;
      r_wr       <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= 16'd0;
      r_wdata    <= 16'd0;
      r_if_rdata <= 16'd0;
      r_dm_rdata <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_grant) begin
        r_owner_dm <= w_pick_dm;
        r_wr       <= w_pick_dm & dm_wr;
        r_err      <= w_req_addr[0];
        r_addr     <= w_req_addr;
        r_wdata    <= w_pick_dm ? dm_wdata : 16'd0;
      end
      // Read data lands only in the owner's register; stores leave both untouched.
      if (r_state == S_ACCESS && !r_wr) begin
        if (r_owner_dm) begin
          r_dm_rdata <= mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_enable = (r_state == S_ACCESS);
  assign mem_wr     = (r_state == S_ACCESS) & r_wr;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign busy       = (r_state != S_IDLE);

  assign if_done  = (r_state == S_RESP) & ~r_owner_dm;
  assign dm_done  = (r_state == S_RESP) & r_owner_dm;
  assign if_err   = if_done & r_err;
  assign dm_err   = dm_done & r_err;
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 has no wait states, instance 1 has three.
// Expected completions are queued by the stimulus and retired by an independent monitor.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        preload;
  int          cyc;

  logic        if_req     [2];
  logic [15:0] if_addr    [2];
  logic [15:0] if_rdata   [2];
  logic        if_done    [2];
  logic        if_err     [2];
  logic        dm_req     [2];
  logic        dm_wr      [2];
  logic [15:0] dm_addr    [2];
  logic [15:0] dm_wdata   [2];
  logic [15:0] dm_rdata   [2];
  logic        dm_done    [2];
  logic        dm_err     [2];
  logic        mem_enable [2];
  logic        mem_wr     [2];
  logic [15:0] mem_addr   [2];
  logic [15:0] mem_wdata  [2];
  logic [15:0] mem_rdata  [2];
  logic        busy       [2];

  logic [15:0] mem [2][256];

  typedef struct {
    int          d;
    bit          dm;
    bit          err;
    logic [15:0] ird;
    logic [15:0] drd;
    int          at;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] sh_if [2];
  logic [15:0] sh_dm [2];
  int          checks;
  int          errors;
  int          en_cnt   [2];
  int          busy_cnt [2];
  int          last_acc [2];

  mem_arbiter #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]),
    .if_done(if_done[0]), .if_err(if_err[0]),
    .dm_req(dm_req[0]), .dm_wr(dm_wr[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_rdata(dm_rdata[0]), .dm_done(dm_done[0]), .dm_err(dm_err[0]),
    .mem_enable(mem_enable[0]), .mem_wr(mem_wr[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  mem_arbiter #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]),
    .if_done(if_done[1]), .if_err(if_err[1]),
    .dm_req(dm_req[1]), .dm_wr(dm_wr[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_rdata(dm_rdata[1]), .dm_done(dm_done[1]), .dm_err(dm_err[1]),
    .mem_enable(mem_enable[1]), .mem_wr(mem_wr[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, writes dropped while rst is high.
  always @(posedge clk) begin
    if (preload) begin
      mem[0][16] <= 16'h5A5A;
      mem[0][17] <= 16'h7777;
      mem[1][0]  <= 16'hCAFE;
    end else if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (mem_enable[d] && mem_wr[d]) mem[d][mem_addr[d][8:1]] <= mem_wdata[d];
      end
    end
  end
  assign mem_rdata[0] = mem[0][mem_addr[0][8:1]];
  assign mem_rdata[1] = mem[1][mem_addr[1][8:1]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: retires one scoreboard entry per done pulse, tallies memory/busy activity.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_enable[d] === 1'b1) begin
        en_cnt[d]++;
        last_acc[d] = cyc;
      end
      if (busy[d] === 1'b1) busy_cnt[d]++;
      if (if_done[d] === 1'b1 || dm_done[d] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("stray_done", 64'({if_done[d], dm_done[d]}), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("dut_index", 64'(d), 64'(e.d));
          chk("owner", 64'({dm_done[d], if_done[d]}), 64'({e.dm, ~e.dm}));
          chk("err", 64'({dm_err[d], if_err[d]}), 64'({e.dm & e.err, ~e.dm & e.err}));
          chk("if_rdata", 64'(if_rdata[d]), 64'(e.ird));
          chk("dm_rdata", 64'(dm_rdata[d]), 64'(e.drd));
          chk("done_cycle", 64'(cyc), 64'(e.at));
        end
      end
    end
  end

  task automatic expect_done(input int d, input bit dm, input bit wr, input logic [15:0] addr,
                             input logic [15:0] rd, input int at);
    exp_t e;
    if (!addr[0] && !wr) begin
      if (dm) sh_dm[d] = rd;
      else    sh_if[d] = rd;
    end
    e = '{d, dm, addr[0], sh_if[d], sh_dm[d], at};
    sb.push_back(e);
  endtask

  task automatic drive(input int d, input bit dm, input bit wr, input logic [15:0] addr,
                       input logic [15:0] wdata);
    if (dm) begin
      dm_req[d] = 1'b1; dm_wr[d] = wr; dm_addr[d] = addr; dm_wdata[d] = wdata;
    end else begin
      if_req[d] = 1'b1; if_addr[d] = addr;
    end
  endtask

  // Holds each request until it has completed n_* times, then drops it right after done.
  task automatic run_hold(input int d, input int n_dm, input int n_if, input int budget);
    int cd = 0;
    int ci = 0;
    int t  = 0;
    while ((dm_req[d] || if_req[d] || busy[d]) && t < budget) begin
      @(posedge clk); #1;
      t++;
      if (dm_done[d]) begin
        cd++;
        if (cd >= n_dm) dm_req[d] = 1'b0;
      end
      if (if_done[d]) begin
        ci++;
        if (ci >= n_if) if_req[d] = 1'b0;
      end
    end
    if (t >= budget) begin
      chk("timeout", 64'(t), 64'(0));
      dm_req[d] = 1'b0;
      if_req[d] = 1'b0;
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_ctrl", 64'({busy[d], mem_enable[d], mem_wr[d], if_done[d], if_err[d], dm_done[d], dm_err[d]}), 64'(0));
    chk("rst_data", {mem_addr[d], mem_wdata[d], if_rdata[d], dm_rdata[d]}, 64'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      sh_if[d] = 16'h0;
      sh_dm[d] = 16'h0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e0;
    int b0;
    checks = 0; errors = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 0; if_addr[d] = 0; dm_req[d] = 0; dm_wr[d] = 0; dm_addr[d] = 0; dm_wdata[d] = 0;
      sh_if[d] = 0; sh_dm[d] = 0; en_cnt[d] = 0; busy_cnt[d] = 0; last_acc[d] = 0;
    end
    rst = 1'b1;
    preload = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    chk_reset(0);
    chk_reset(1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Store 0xBEEF to 0x0010, then fetch it back.
    e0 = en_cnt[0];
    n = cyc;
    drive(0, 1, 1, 16'h0010, 16'hBEEF);
    expect_done(0, 1, 1, 16'h0010, 16'h0, n + 2);
    run_hold(0, 1, 0, 20);
    n = cyc;
    drive(0, 0, 0, 16'h0010, 16'h0);
    expect_done(0, 0, 0, 16'h0010, 16'hBEEF, n + 2);
    run_hold(0, 0, 1, 20);
    chk("store_fetch_accesses", 64'(en_cnt[0] - e0), 64'(2));

    // First conflict: dm wins in both arbitration modes.
    n = cyc;
    drive(0, 1, 0, 16'h0020, 16'h0);
    drive(0, 0, 0, 16'h0022, 16'h0);
    expect_done(0, 1, 0, 16'h0020, 16'h5A5A, n + 2);
    expect_done(0, 0, 0, 16'h0022, 16'h7777, n + 5);
    run_hold(0, 1, 1, 30);

    // Misaligned fetch and load: immediate error, no memory access.
    e0 = en_cnt[0];
    n = cyc;
    drive(0, 0, 0, 16'h0011, 16'h0);
    expect_done(0, 0, 0, 16'h0011, 16'h0, n + 1);
    run_hold(0, 0, 1, 20);
    n = cyc;
    drive(0, 1, 0, 16'h0003, 16'h0);
    expect_done(0, 1, 0, 16'h0003, 16'h0, n + 1);
    run_hold(0, 1, 0, 20);
    chk("misaligned_no_access", 64'(en_cnt[0] - e0), 64'(0));

    // Second conflict, last grant was dm.
    n = cyc;
    drive(0, 1, 0, 16'h0010, 16'h0);
    drive(0, 0, 0, 16'h0020, 16'h0);
`ifdef ARB_ROUND_ROBIN_EN
    expect_done(0, 0, 0, 16'h0020, 16'h5A5A, n + 2);
    expect_done(0, 1, 0, 16'h0010, 16'hBEEF, n + 5);
`else
    expect_done(0, 1, 0, 16'h0010, 16'hBEEF, n + 2);
    expect_done(0, 0, 0, 16'h0020, 16'h5A5A, n + 5);
`endif
    run_hold(0, 1, 1, 30);

    // Three wait states: access at grant+4, done at grant+5.
    e0 = en_cnt[1];
    b0 = busy_cnt[1];
    n = cyc;
    drive(1, 0, 0, 16'h0000, 16'h0);
    expect_done(1, 0, 0, 16'h0000, 16'hCAFE, n + 5);
    run_hold(1, 0, 1, 30);
    chk("wait_access_cycle", 64'(last_acc[1]), 64'(n + 4));
    chk("wait_access_count", 64'(en_cnt[1] - e0), 64'(1));
    chk("wait_busy_cycles", 64'(busy_cnt[1] - b0), 64'(5));

    // Reset during WAIT: no access, no done.
    e0 = en_cnt[1];
    drive(1, 0, 0, 16'h0000, 16'h0);
    @(posedge clk); #1;
    chk("in_wait_busy", 64'(busy[1]), 64'(1));
    if_req[1] = 1'b0;
    pulse_reset();
    repeat (6) @(posedge clk);
    #1;
    chk("wait_reset_no_access", 64'(en_cnt[1] - e0), 64'(0));

    // Reset during a store's ACCESS cycle: write discarded.
    drive(0, 1, 1, 16'h0020, 16'h1234);
    @(posedge clk); #1;
    chk("in_access_strobes", 64'({mem_enable[0], mem_wr[0], mem_addr[0]}), 64'({2'b11, 16'h0020}));
    dm_req[0] = 1'b0;
    pulse_reset();
    repeat (3) @(posedge clk);
    #1;
    n = cyc;
    drive(0, 0, 0, 16'h0020, 16'h0);
    expect_done(0, 0, 0, 16'h0020, 16'h5A5A, n + 2);
    run_hold(0, 0, 1, 20);

    // Both requests held continuously.
    n = cyc;
    drive(0, 1, 0, 16'h0010, 16'h0);
    drive(0, 0, 0, 16'h0022, 16'h0);
`ifdef ARB_ROUND_ROBIN_EN
    expect_done(0, 1, 0, 16'h0010, 16'hBEEF, n + 2);
    expect_done(0, 0, 0, 16'h0022, 16'h7777, n + 5);
    expect_done(0, 1, 0, 16'h0010, 16'hBEEF, n + 8);
    expect_done(0, 0, 0, 16'h0022, 16'h7777, n + 11);
    run_hold(0, 2, 2, 60);
`else
    for (int k = 0; k < 4; k++) expect_done(0, 1, 0, 16'h0010, 16'hBEEF, n + 2 + 3 * k);
    expect_done(0, 0, 0, 16'h0022, 16'h7777, n + 14);
    run_hold(0, 4, 1, 60);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
